// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: performs each 32-bit load/store as two halfword
// phases on an external asynchronous 16-bit SRAM and stalls the pipeline until done.
module mem_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] offset;
  logic [16:0] word_q;
  logic [31:0] data_q;
  logic        wr_q;
  logic        req;
  logic        last;
  logic        unused_offset_bits;

  assign req    = mem_read | mem_write;
  assign offset = address - 32'(BASE_ADDR);
  assign last   = (cnt == 4'(WAIT_CYCLES));
  assign ready  = ~req | (state == DONE);

  // Only word-address bits within the SRAM window matter; the rest wrap away.
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HI: begin
        if (last) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pins are purely a function of the phase; outside LO/HI the bus is parked.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == LO || state == HI) begin
      sram_addr = {word_q, (state == HI)};
      if (wr_q) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? data_q[31:16] : data_q[15:0];
      end
    end
  end

  // Write wins when both controls are high, so a combined request never loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        word_q <= offset[18:2];
        data_q <= write_data;
        wr_q   <= mem_write;
      end
      if (!wr_q && last) begin
        if (state == LO) read_data[15:0]  <= sram_dq_in;
        if (state == HI) read_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: one instance with one wait cycle, one with none,
// each attached to a small behavioural SRAM.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mem_read1, mem_write1, ready1, sram_dq_oe1, sram_we_n1;
  logic [31:0] address1, write_data1, read_data1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;

  logic        mem_read0, mem_write0, ready0, sram_dq_oe0, sram_we_n0;
  logic [31:0] address0, write_data0, read_data0;
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0, sram_dq_in0;

  logic [15:0] mem1 [0:63];
  logic [15:0] mem0 [0:63];
  logic        pl_en1, pl_en0;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [36:0] obs, exp_v;

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read1), .mem_write(mem_write1),
    .address(address1), .write_data(write_data1), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
    .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
  );

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(mem_read0), .mem_write(mem_write0),
    .address(address0), .write_data(write_data0), .read_data(read_data0),
    .ready(ready0), .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0),
    .sram_dq_oe(sram_dq_oe0), .sram_dq_in(sram_dq_in0), .sram_we_n(sram_we_n0)
  );

  // Behavioural SRAMs: write on any clock edge where we_n is low, read asynchronously.
  always @(posedge clk) begin
    if (pl_en1) mem1[pl_addr] <= pl_data;
    else if (!sram_we_n1) mem1[sram_addr1[5:0]] <= sram_dq_out1;
    if (pl_en0) mem0[pl_addr] <= pl_data;
    else if (!sram_we_n0) mem0[sram_addr0[5:0]] <= sram_dq_out0;
  end
  assign sram_dq_in1 = mem1[sram_addr1[5:0]];
  assign sram_dq_in0 = mem0[sram_addr0[5:0]];

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    obs   = {ready1, sram_we_n1, sram_dq_oe1, sram_addr1, sram_dq_out1};
    exp_v = {1'b1, 1'b1, 1'b0, 18'd0, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL reset_pins_w1: got %h, expected %h", obs, exp_v);
    end
    n_cmp++;
    if (read_data1 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rdata_w1: got %h, expected %h", read_data1, 32'h0);
    end
    obs   = {ready0, sram_we_n0, sram_dq_oe0, sram_addr0, sram_dq_out0};
    n_cmp++;
    if (obs !== exp_v || read_data0 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_w0: got %h/%h, expected %h/%h", obs, read_data0, exp_v, 32'h0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store;
    address1 = 32'd1032; write_data1 = 32'hDEADBEEF; mem_write1 = 1'b1;
    #1;
    n_cmp++;
    if (ready1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store_c0_ready: got %b, expected 0", ready1);
    end
    for (int c = 1; c <= 5; c++) begin
      step();
      case (c)
        1, 2:    exp_v = {1'b0, 1'b0, 1'b1, 18'd4, 16'hBEEF};
        3, 4:    exp_v = {1'b0, 1'b0, 1'b1, 18'd5, 16'hDEAD};
        default: exp_v = {1'b1, 1'b1, 1'b0, 18'd0, 16'h0000};
      endcase
      obs = {ready1, sram_we_n1, sram_dq_oe1, sram_addr1, sram_dq_out1};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL store_c%0d: got %h, expected %h", c, obs, exp_v);
      end
    end
    mem_write1 = 1'b0;
    step();
    n_cmp++;
    if (mem1[4] !== 16'hBEEF || mem1[5] !== 16'hDEAD) begin
      n_fail++;
      $display("[TB] FAIL store_sram: got %h_%h, expected dead_beef", mem1[5], mem1[4]);
    end
  endtask

  task automatic test_load;
    pl_addr = 6'd4; pl_data = 16'h1234; pl_en1 = 1'b1;
    step();
    pl_addr = 6'd5; pl_data = 16'hABCD;
    step();
    pl_en1 = 1'b0;
    address1 = 32'd1032; mem_read1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      case (c)
        1, 2:    exp_v = {1'b0, 1'b1, 1'b0, 18'd4, 16'h0000};
        3, 4:    exp_v = {1'b0, 1'b1, 1'b0, 18'd5, 16'h0000};
        default: exp_v = {1'b1, 1'b1, 1'b0, 18'd0, 16'h0000};
      endcase
      obs = {ready1, sram_we_n1, sram_dq_oe1, sram_addr1, sram_dq_out1};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL load_c%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (c == 3) begin
        n_cmp++;
        if (read_data1 !== 32'h00001234) begin
          n_fail++;
          $display("[TB] FAIL load_lo_half: got %h, expected %h", read_data1, 32'h00001234);
        end
      end
    end
    n_cmp++;
    if (read_data1 !== 32'hABCD1234) begin
      n_fail++;
      $display("[TB] FAIL load_word: got %h, expected %h", read_data1, 32'hABCD1234);
    end
    mem_read1 = 1'b0;
    step();
    step();
    n_cmp++;
    if (read_data1 !== 32'hABCD1234) begin
      n_fail++;
      $display("[TB] FAIL load_hold: got %h, expected %h", read_data1, 32'hABCD1234);
    end
  endtask

  task automatic test_back_to_back;
    address1 = 32'd1032; write_data1 = 32'hDEADBEEF; mem_write1 = 1'b1;
    for (int c = 1; c <= 5; c++) step();
    n_cmp++;
    if (ready1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_store_done: got %b, expected 1", ready1);
    end
    mem_write1 = 1'b0; mem_read1 = 1'b1; write_data1 = 32'h0;
    step();
    obs   = {ready1, sram_we_n1, sram_dq_oe1, sram_addr1, sram_dq_out1};
    exp_v = {1'b0, 1'b1, 1'b0, 18'd0, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle_accept: got %h, expected %h", obs, exp_v);
    end
    step();
    n_cmp++;
    if (sram_addr1 !== 18'd4 || sram_we_n1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_load_start: got addr %h we_n %b, expected 4 1", sram_addr1, sram_we_n1);
    end
    for (int c = 8; c <= 11; c++) step();
    n_cmp++;
    if (ready1 !== 1'b1 || read_data1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL b2b_load_word: got %b %h, expected 1 deadbeef", ready1, read_data1);
    end
    mem_read1 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid;
    address1 = 32'd1032; write_data1 = 32'h11112222; mem_write1 = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    obs   = {ready1, sram_we_n1, sram_dq_oe1, sram_addr1, sram_dq_out1};
    exp_v = {1'b0, 1'b0, 1'b1, 18'd5, 16'h1111};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL rstmid_hi: got %h, expected %h", obs, exp_v);
    end
    rst = 1'b1;
    step();
    obs   = {ready1, sram_we_n1, sram_dq_oe1, sram_addr1, sram_dq_out1};
    exp_v = {1'b0, 1'b1, 1'b0, 18'd0, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL rstmid_idle: got %h, expected %h", obs, exp_v);
    end
    rst = 1'b0; mem_write1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      obs   = {ready1, sram_we_n1, sram_dq_oe1, sram_addr1, sram_dq_out1};
      exp_v = {1'b1, 1'b1, 1'b0, 18'd0, 16'h0000};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL rstmid_quiet%0d: got %h, expected %h", c, obs, exp_v);
      end
    end
    n_cmp++;
    if (mem1[4] !== 16'h2222 || mem1[5] !== 16'h1111) begin
      n_fail++;
      $display("[TB] FAIL rstmid_sram: got %h_%h, expected 1111_2222", mem1[5], mem1[4]);
    end
  endtask

  task automatic test_w0_load;
    pl_addr = 6'd2; pl_data = 16'h5555; pl_en0 = 1'b1;
    step();
    pl_addr = 6'd3; pl_data = 16'h7777;
    step();
    pl_en0 = 1'b0;
    address0 = 32'd1028; mem_read0 = 1'b1;
    #1;
    n_cmp++;
    if (ready0 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL w0_load_c0: got %b, expected 0", ready0);
    end
    step();
    n_cmp++;
    if (sram_addr0 !== 18'd2 || ready0 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL w0_load_c1: got %h %b, expected 2 0", sram_addr0, ready0);
    end
    step();
    n_cmp++;
    if (sram_addr0 !== 18'd3 || ready0 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL w0_load_c2: got %h %b, expected 3 0", sram_addr0, ready0);
    end
    step();
    n_cmp++;
    if (ready0 !== 1'b1 || read_data0 !== 32'h77775555) begin
      n_fail++;
      $display("[TB] FAIL w0_load_c3: got %b %h, expected 1 77775555", ready0, read_data0);
    end
    mem_read0 = 1'b0;
    step();
  endtask

  task automatic test_both_high;
    address0 = 32'd1028; write_data0 = 32'h89ABCDEF; mem_read0 = 1'b1; mem_write0 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      case (c)
        1:       exp_v = {1'b0, 1'b0, 1'b1, 18'd2, 16'hCDEF};
        2:       exp_v = {1'b0, 1'b0, 1'b1, 18'd3, 16'h89AB};
        default: exp_v = {1'b1, 1'b1, 1'b0, 18'd0, 16'h0000};
      endcase
      obs = {ready0, sram_we_n0, sram_dq_oe0, sram_addr0, sram_dq_out0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL both_c%0d: got %h, expected %h", c, obs, exp_v);
      end
    end
    n_cmp++;
    if (read_data0 !== 32'h77775555) begin
      n_fail++;
      $display("[TB] FAIL both_rdata_kept: got %h, expected %h", read_data0, 32'h77775555);
    end
    mem_read0 = 1'b0; mem_write0 = 1'b0;
    step();
    n_cmp++;
    if (mem0[2] !== 16'hCDEF || mem0[3] !== 16'h89AB) begin
      n_fail++;
      $display("[TB] FAIL both_sram: got %h_%h, expected 89ab_cdef", mem0[3], mem0[2]);
    end
  endtask

  task automatic test_wrap;
    address0 = 32'd1020; mem_read0 = 1'b1;
    step();
    n_cmp++;
    if (sram_addr0 !== 18'h3FFFE) begin
      n_fail++;
      $display("[TB] FAIL wrap_lo: got %h, expected %h", sram_addr0, 18'h3FFFE);
    end
    step();
    n_cmp++;
    if (sram_addr0 !== 18'h3FFFF) begin
      n_fail++;
      $display("[TB] FAIL wrap_hi: got %h, expected %h", sram_addr0, 18'h3FFFF);
    end
    step();
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_done: got %b, expected 1", ready0);
    end
    mem_read0 = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    mem_read1 = 1'b0; mem_write1 = 1'b0; address1 = '0; write_data1 = '0;
    mem_read0 = 1'b0; mem_write0 = 1'b0; address0 = '0; write_data0 = '0;
    pl_en1 = 1'b0; pl_en0 = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_w0_load();
    test_both_high();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
